// File: rtl/motor_scheduler.sv
// Round-robin motor run-slot scheduler with fault latching and per-slot timing.
// Optional dead-time gap between slots: define MOTOR_SCHEDULER_DEADTIME_EN.
module motor_scheduler #(
  parameter int F_CLK_HZ    = 25_000_000,
  parameter int N_MOTORS    = 4,
  parameter int NORMAL_SECS = 30,
  parameter int TEST_SECS   = 3,
  parameter int DEAD_MS     = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_start,
  input  logic                        cmd_stop,
  input  logic                        test_mode,
  input  logic [N_MOTORS-1:0]         motor_en,
  input  logic [N_MOTORS-1:0]         motor_fault,
  output logic [N_MOTORS-1:0]         motor_on,
  output logic                        running,
  output logic [$clog2(N_MOTORS)-1:0] active_idx,
  output logic [N_MOTORS-1:0]         fault_latched
);

  localparam int IW = $clog2(N_MOTORS);
  localparam longint unsigned NORMAL_CYC = longint'(NORMAL_SECS) * longint'(F_CLK_HZ);
  localparam longint unsigned TEST_CYC   = longint'(TEST_SECS) * longint'(F_CLK_HZ);
  localparam longint unsigned DEAD_RAW   = longint'(DEAD_MS) * longint'(F_CLK_HZ) / 64'd1000;
  localparam longint unsigned DEAD_CYC   = (DEAD_RAW == 64'd0) ? 64'd1 : DEAD_RAW;
  localparam longint unsigned MAX_A      = (NORMAL_CYC > TEST_CYC) ? NORMAL_CYC : TEST_CYC;
  localparam longint unsigned MAX_CYC    = (MAX_A > DEAD_CYC) ? MAX_A : DEAD_CYC;
  localparam int CW = $clog2(MAX_CYC + 64'd1);

`ifdef MOTOR_SCHEDULER_DEADTIME_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
`endif

  state_t              state_r, state_s;
  logic [N_MOTORS-1:0] motor_on_r, motor_on_s;
  logic                running_r, running_s;
  logic [IW-1:0]       active_idx_r, active_idx_s;
  logic [N_MOTORS-1:0] fault_latched_r, fault_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [CW-1:0]       slot_len_s;
  logic [N_MOTORS-1:0] elig_s;
  logic [IW-1:0]       start_idx_s, pick_s;
  logic                found_s, expire_s, load_run_s, load_dead_s;

  // First eligible index at or after start, wrapping; MSB flags success.
  function automatic logic [IW:0] rr_pick(input logic [N_MOTORS-1:0] elig,
                                          input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int k = 0; k < N_MOTORS; k++) begin
      cand = IW'((int'(start) + k) % N_MOTORS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: stop beats start and expiry; fault or disable ends the slot early.
  always_comb begin
    elig_s      = motor_en & ~motor_fault & ~fault_latched_r;
    if (state_r == ST_IDLE) begin
      start_idx_s = {IW{1'b0}};
    end else if (active_idx_r == IW'(N_MOTORS - 1)) begin
      start_idx_s = {IW{1'b0}};
    end else begin
      start_idx_s = active_idx_r + IW'(1);
    end
    {found_s, pick_s} = rr_pick(elig_s, start_idx_s);
    expire_s    = (cnt_r == {CW{1'b0}}) || !motor_en[active_idx_r] || motor_fault[active_idx_r];
    state_s     = state_r;
    load_run_s  = 1'b0;
    load_dead_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_start && !cmd_stop && found_s) begin
          state_s    = ST_RUN;
          load_run_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_stop) begin
          state_s = ST_IDLE;
        end else if (expire_s) begin
`ifdef MOTOR_SCHEDULER_DEADTIME_EN
          state_s     = ST_DEAD;
          load_dead_s = 1'b1;
`else
          if (found_s) begin
            state_s    = ST_RUN;
            load_run_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
`endif
        end else begin
          state_s = ST_RUN;
        end
      end
`ifdef MOTOR_SCHEDULER_DEADTIME_EN
      ST_DEAD: begin
        if (cmd_stop) begin
          state_s = ST_IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          if (found_s) begin
            state_s    = ST_RUN;
            load_run_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DEAD;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and the slot/dead counter.
  always_comb begin
    slot_len_s = test_mode ? CW'(TEST_CYC - 64'd1) : CW'(NORMAL_CYC - 64'd1);
    if (load_run_s) begin
      motor_on_s = {{(N_MOTORS-1){1'b0}}, 1'b1} << pick_s;
    end else if (state_s == ST_RUN) begin
      motor_on_s = motor_on_r;
    end else begin
      motor_on_s = {N_MOTORS{1'b0}};
    end
    running_s    = (state_s != ST_IDLE);
    active_idx_s = load_run_s ? pick_s : active_idx_r;
    if (load_run_s) begin
      cnt_s = slot_len_s;
    end else if (load_dead_s) begin
      cnt_s = CW'(DEAD_CYC - 64'd1);
    end else if ((state_s != ST_IDLE) && (cnt_r != {CW{1'b0}})) begin
      cnt_s = cnt_r - CW'(1);
    end else begin
      cnt_s = {CW{1'b0}};
    end
    fault_s = fault_latched_r | motor_fault;
  end

  // Output and counter registers; active_idx resets to the last index so the first search lands on 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_on_r      <= {N_MOTORS{1'b0}};
      running_r       <= 1'b0;
      active_idx_r    <= IW'(N_MOTORS - 1);
      fault_latched_r <= {N_MOTORS{1'b0}};
      cnt_r           <= {CW{1'b0}};
    end else begin
      motor_on_r      <= motor_on_s;
      running_r       <= running_s;
      active_idx_r    <= active_idx_s;
      fault_latched_r <= fault_s;
      cnt_r           <= cnt_s;
    end
  end

  assign motor_on      = motor_on_r;
  assign running       = running_r;
  assign active_idx    = active_idx_r;
  assign fault_latched = fault_latched_r;

endmodule

// File: tb/tb_motor_scheduler.sv
// Directed scoreboard bench for motor_scheduler (F_CLK_HZ=10, 3 s / 1 s slots, 200 ms dead time).
module tb_motor_scheduler;

`ifdef MOTOR_SCHEDULER_DEADTIME_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_start;
  logic       cmd_stop;
  logic       test_mode;
  logic [3:0] motor_en;
  logic [3:0] motor_fault;
  logic [3:0] motor_on;
  logic       running;
  logic [1:0] active_idx;
  logic [3:0] fault_latched;

  typedef struct {
    logic [3:0] mon;
    logic       run;
    logic [1:0] idx;
    logic [3:0] fl;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  motor_scheduler #(
    .F_CLK_HZ(10), .N_MOTORS(4), .NORMAL_SECS(3), .TEST_SECS(1), .DEAD_MS(200)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .test_mode(test_mode), .motor_en(motor_en), .motor_fault(motor_fault),
    .motor_on(motor_on), .running(running), .active_idx(active_idx),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic check_front();
    exp_t e;
    e = sb_q.pop_front();
    n_vec++;
    assert (motor_on === e.mon) else begin
      n_err++;
      $error("FAIL %s motor_on: observed %b expected %b", e.tag, motor_on, e.mon);
    end
    n_vec++;
    assert (running === e.run) else begin
      n_err++;
      $error("FAIL %s running: observed %b expected %b", e.tag, running, e.run);
    end
    n_vec++;
    assert (active_idx === e.idx) else begin
      n_err++;
      $error("FAIL %s active_idx: observed %0d expected %0d", e.tag, active_idx, e.idx);
    end
    n_vec++;
    assert (fault_latched === e.fl) else begin
      n_err++;
      $error("FAIL %s fault_latched: observed %b expected %b", e.tag, fault_latched, e.fl);
    end
  endtask

  // Push n expected cycles, advancing one clock per entry and checking just after the edge.
  task automatic exp_n(input int n, input logic [3:0] mon, input logic run,
                       input logic [1:0] idx, input logic [3:0] fl, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.mon = mon; e.run = run; e.idx = idx; e.fl = fl; e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_front();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; test_mode = 1'b0;
    motor_en = 4'b0000; motor_fault = 4'b0000;
    exp_n(2, 4'b0000, 1'b0, 2'd3, 4'b0000, "reset");
    rst = 1'b0;

    // All enabled, normal slots: motor 0 for 30 cycles, then motor 1.
    motor_en = 4'b1111;
    cmd_start = 1'b1;
    exp_n(1, 4'b0001, 1'b1, 2'd0, 4'b0000, "start_lat");
    cmd_start = 1'b0;
    exp_n(29, 4'b0001, 1'b1, 2'd0, 4'b0000, "slot0_normal");
    exp_n(GAP, 4'b0000, 1'b1, 2'd0, 4'b0000, "dead0");
    exp_n(1, 4'b0010, 1'b1, 2'd1, 4'b0000, "handoff1");
    // Stop and start together: stop wins, active_idx held.
    cmd_stop = 1'b1; cmd_start = 1'b1;
    exp_n(1, 4'b0000, 1'b0, 2'd1, 4'b0000, "stop_wins");
    cmd_stop = 1'b0; cmd_start = 1'b0;
    exp_n(3, 4'b0000, 1'b0, 2'd1, 4'b0000, "idle_hold");

    // motor_en=0101 test slots: 0,2,0; test_mode cleared mid-slot takes effect next slot.
    motor_en = 4'b0101; test_mode = 1'b1;
    cmd_start = 1'b1;
    exp_n(1, 4'b0001, 1'b1, 2'd0, 4'b0000, "rr_m0");
    cmd_start = 1'b0;
    exp_n(9, 4'b0001, 1'b1, 2'd0, 4'b0000, "rr_m0");
    exp_n(GAP, 4'b0000, 1'b1, 2'd0, 4'b0000, "rr_dead");
    exp_n(5, 4'b0100, 1'b1, 2'd2, 4'b0000, "rr_m2");
    test_mode = 1'b0;
    exp_n(5, 4'b0100, 1'b1, 2'd2, 4'b0000, "rr_m2_tail");
    exp_n(GAP, 4'b0000, 1'b1, 2'd2, 4'b0000, "rr_dead");
    exp_n(30, 4'b0001, 1'b1, 2'd0, 4'b0000, "rr_m0_normal");
    cmd_stop = 1'b1;
    exp_n(1, 4'b0000, 1'b0, 2'd0, 4'b0000, "stop_at_expiry");
    cmd_stop = 1'b0;

    // Only motor 2 eligible: re-run, then disabled mid-slot -> IDLE.
    motor_en = 4'b0100; test_mode = 1'b1;
    cmd_start = 1'b1;
    exp_n(1, 4'b0100, 1'b1, 2'd2, 4'b0000, "solo_m2");
    cmd_start = 1'b0;
    exp_n(9, 4'b0100, 1'b1, 2'd2, 4'b0000, "solo_m2");
    exp_n(GAP, 4'b0000, 1'b1, 2'd2, 4'b0000, "solo_dead");
    exp_n(5, 4'b0100, 1'b1, 2'd2, 4'b0000, "solo_rerun");
    motor_en = 4'b0000;
    exp_n(GAP, 4'b0000, 1'b1, 2'd2, 4'b0000, "disable_dead");
    exp_n(2, 4'b0000, 1'b0, 2'd2, 4'b0000, "disable_idle");
    cmd_start = 1'b1;
    exp_n(1, 4'b0000, 1'b0, 2'd2, 4'b0000, "start_none_elig");
    cmd_start = 1'b0;

    // Fault on active motor 0 at cycle 5; later a fault on idle motor 3.
    motor_en = 4'b1111;
    cmd_start = 1'b1;
    exp_n(1, 4'b0001, 1'b1, 2'd0, 4'b0000, "flt_m0");
    cmd_start = 1'b0;
    exp_n(4, 4'b0001, 1'b1, 2'd0, 4'b0000, "flt_m0");
    motor_fault = 4'b0001;
`ifdef MOTOR_SCHEDULER_DEADTIME_EN
    exp_n(1, 4'b0000, 1'b1, 2'd0, 4'b0001, "fault_gap");
    motor_fault = 4'b0000;
    exp_n(1, 4'b0000, 1'b1, 2'd0, 4'b0001, "fault_gap");
    exp_n(10, 4'b0010, 1'b1, 2'd1, 4'b0001, "fault_m1");
`else
    exp_n(1, 4'b0010, 1'b1, 2'd1, 4'b0001, "fault_handoff");
    motor_fault = 4'b0000;
    exp_n(9, 4'b0010, 1'b1, 2'd1, 4'b0001, "fault_m1");
`endif
    exp_n(GAP, 4'b0000, 1'b1, 2'd1, 4'b0001, "flt_dead");
    exp_n(3, 4'b0100, 1'b1, 2'd2, 4'b0001, "flt_m2");
    motor_fault = 4'b1000;
    exp_n(1, 4'b0100, 1'b1, 2'd2, 4'b1001, "side_fault");
    motor_fault = 4'b0000;
    exp_n(6, 4'b0100, 1'b1, 2'd2, 4'b1001, "flt_m2_tail");
    exp_n(GAP, 4'b0000, 1'b1, 2'd2, 4'b1001, "flt_dead");
    exp_n(5, 4'b0010, 1'b1, 2'd1, 4'b1001, "skip_faulted");

    // Reset mid-RUN beats start; start afterwards picks motor 0 again.
    rst = 1'b1; cmd_start = 1'b1;
    exp_n(1, 4'b0000, 1'b0, 2'd3, 4'b0000, "rst_midrun");
    rst = 1'b0;
    exp_n(1, 4'b0001, 1'b1, 2'd0, 4'b0000, "post_rst_start");
    cmd_start = 1'b0;
    exp_n(3, 4'b0001, 1'b1, 2'd0, 4'b0000, "post_rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
